// File: rtl/adpll_pkg.sv
// adpll_pkg: shared types and widths for the ADPLL lock monitor and phase detector.
package adpll_pkg;
  typedef enum logic [1:0] {
    UNLOCKED  = 2'b00,
    ACQUIRING = 2'b01,
    LOCKED    = 2'b10,
    SLIPPING  = 2'b11
  } lock_state_t;
  localparam int PDET_WIDTH = 8;
  localparam int SLIP_CNT_W = 16;
endpackage

// File: rtl/ref_edge_sync.sv
// ref_edge_sync: 2-flop synchroniser plus history flop giving a one-cycle rising-edge pulse.
// Ports: i_clk clock, i_rst async active-high reset, i_async asynchronous input, o_edge rising-edge pulse.
module ref_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_edge
);
  logic r_sync1, r_sync2, r_sync3;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) {r_sync3, r_sync2, r_sync1} <= 3'b000;
    else {r_sync3, r_sync2, r_sync1} <= {r_sync2, r_sync1, i_async};
  assign o_edge = r_sync2 & ~r_sync3;
endmodule

// File: rtl/adpll_lock_monitor.sv
// adpll_lock_monitor: hysteretic lock detector on sampled phase error with reference-loss watchdog.
// Ports: fpga_clk_i clock, reset_i async active-high reset, enable_i monitor enable,
//   reference_i async reference, error_i signed phase error, lock_window_i in-window threshold,
//   clear_stats_i stats clear; outputs sample_valid_o, abs_error_o, state_o, locked_o,
//   ref_lost_o, slip_count_o, peak_error_o.
// Optional statistics (slip_count_o, peak_error_o) are built when LOCK_MON_STATS_EN is defined.
module adpll_lock_monitor
  import adpll_pkg::*;
#(
  parameter int WIDTH        = PDET_WIDTH,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4,
  parameter int REF_TIMEOUT  = 1024,
  parameter int SLIP_THRESH  = 64
) (
  input  logic                    fpga_clk_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic                    reference_i,
  input  logic signed [WIDTH-1:0] error_i,
  input  logic [WIDTH-2:0]        lock_window_i,
  input  logic                    clear_stats_i,
  output logic                    sample_valid_o,
  output logic [WIDTH-2:0]        abs_error_o,
  output logic [1:0]              state_o,
  output logic                    locked_o,
  output logic                    ref_lost_o,
  output logic [SLIP_CNT_W-1:0]   slip_count_o,
  output logic [WIDTH-2:0]        peak_error_o
);
  localparam int MAXC = LOCK_COUNT > UNLOCK_COUNT ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam int WD_W = $clog2(REF_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LOCK_N = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] UNLOCK_N = CNT_W'(UNLOCK_COUNT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(REF_TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(REF_TIMEOUT);
  logic                    w_edge, w_in_win, w_timeout;
  logic signed [WIDTH-1:0] w_neg;
  logic [WIDTH-2:0]        w_abs, r_abs;
  lock_state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [WD_W-1:0]         r_wd;
  logic                    r_valid, r_lost, r_locked;
  ref_edge_sync u_sync (
    .i_clk  (fpga_clk_i),
    .i_rst  (reset_i),
    .i_async(reference_i),
    .o_edge (w_edge)
  );
  // Negating the most negative code wraps back to a negative value; that is the saturation case.
  assign w_neg = -error_i;
  assign w_abs = !error_i[WIDTH-1] ? error_i[WIDTH-2:0] : (w_neg[WIDTH-1] ? '1 : w_neg[WIDTH-2:0]);
  assign w_in_win = w_abs <= lock_window_i;
  // An edge in the timeout cycle clears the counter and suppresses the timeout.
  assign w_timeout = !w_edge && r_wd == WD_LAST;
  assign w_cnt_inc = r_cnt + 1'b1;
  // The run counter is zero in UNLOCKED and LOCKED, so each half of the FSM shares one rule.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = r_cnt;
    if (!enable_i || w_timeout) begin
      w_state_nxt = UNLOCKED;
      w_cnt_nxt = '0;
    end else if (w_edge && !r_state[1]) begin
      w_state_nxt = !w_in_win ? UNLOCKED : (w_cnt_inc == LOCK_N ? LOCKED : ACQUIRING);
      w_cnt_nxt = (!w_in_win || w_cnt_inc == LOCK_N) ? '0 : w_cnt_inc;
    end else if (w_edge) begin
      w_state_nxt = w_in_win ? LOCKED : (w_cnt_inc == UNLOCK_N ? UNLOCKED : SLIPPING);
      w_cnt_nxt = (w_in_win || w_cnt_inc == UNLOCK_N) ? '0 : w_cnt_inc;
    end
  end
  always_ff @(posedge fpga_clk_i or posedge reset_i)
    if (reset_i) begin
      r_state <= UNLOCKED;
      r_cnt <= '0;
      r_locked <= 1'b0;
      r_valid <= 1'b0;
      r_abs <= '0;
      r_wd <= '0;
      r_lost <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
      r_locked <= w_state_nxt[1];
      r_valid <= w_edge;
      r_abs <= w_edge ? w_abs : r_abs;
      r_wd <= w_edge ? '0 : (r_wd == WD_MAX ? r_wd : r_wd + 1'b1);
      r_lost <= w_edge ? 1'b0 : (r_lost | w_timeout);
    end
  assign sample_valid_o = r_valid;
  assign abs_error_o = r_abs;
  assign state_o = r_state;
  assign locked_o = r_locked;
  assign ref_lost_o = r_lost;
`ifdef LOCK_MON_STATS_EN
  localparam logic [WIDTH-2:0] SLIP_T = SLIP_THRESH[WIDTH-2:0];
  logic [SLIP_CNT_W-1:0] r_slip;
  logic [WIDTH-2:0]      r_peak;
  always_ff @(posedge fpga_clk_i or posedge reset_i)
    if (reset_i || clear_stats_i) begin
      r_slip <= '0;
      r_peak <= '0;
    end else if (w_edge) begin
      r_slip <= (w_abs >= SLIP_T && r_slip != '1) ? r_slip + 1'b1 : r_slip;
      r_peak <= w_abs > r_peak ? w_abs : r_peak;
    end
  assign slip_count_o = r_slip;
  assign peak_error_o = r_peak;
`else
  logic w_unused_stats;
  assign w_unused_stats = clear_stats_i ^ (SLIP_THRESH == 0);
  assign slip_count_o = '0;
  assign peak_error_o = '0;
`endif
endmodule
